attack_ctrl: RTL and testbench
==============================

ATTACK_CTRL -- requirements
Module: attack_ctrl

Interface
REQ-001 Parameter FIRE_KEY, default 8'd44, keycode that requests an attack (space).
REQ-002 Parameter RELOAD_KEY, default 8'd21, keycode that requests a reload ('R').
REQ-003 Parameter ACTIVE_FRAMES, default 4, frame ticks the attack sprite stays on (range 1..255).
REQ-004 Parameter COOLDOWN_FRAMES, default 8, frame ticks between attacks (range 1..255).
REQ-005 Parameter AMMO_MAX, default 10, magazine size (range 1..15).
REQ-006 Parameter RELOAD_FRAMES, default 60, frame ticks a reload takes (range 1..255).
REQ-007 Clk  input  1  system clock, 50 MHz.
REQ-008 Reset  input  1  synchronous, active-high reset.
REQ-009 frame_clk  input  1  vertical-sync frame clock, ~60 Hz, asynchronous level.
REQ-010 keycode  input  8  current keyboard usage code; 0 means no key.
REQ-011 Player_Direction  input  2  player facing: 0 down, 1 left, 2 right, 3 up.
REQ-012 attack_on  output  1  attack sprite enable for the sprite overlay.
REQ-013 attack_dir  output  2  facing latched when the current attack started.
REQ-014 hit_pulse  output  1  one-Clk strobe at attack start, for damage logic.
REQ-015 ammo  output  4  rounds remaining.
REQ-016 state  output  2  0 IDLE, 1 ACTIVE, 2 COOLDOWN, 3 RELOAD.

Function
REQ-017 Frame tick SHALL be a one-Clk pulse, registered, asserted the Clk after a 0->1 transition of frame_clk is sampled; frame_clk passes through a two-flop synchroniser first.
REQ-018 IDLE, keycode==FIRE_KEY and ammo>0: the next Clk SHALL enter ACTIVE, latch attack_dir from Player_Direction, clear the frame counter, and decrement ammo by 1.
REQ-019 hit_pulse SHALL be high for exactly the one Clk in which state first reads ACTIVE; it SHALL be low at all other times.
REQ-020 ACTIVE: each frame tick SHALL increment the frame counter; the tick on which the counter equals ACTIVE_FRAMES-1 SHALL move to COOLDOWN and clear the counter.
REQ-021 COOLDOWN: each tick increments; the tick on which the counter equals COOLDOWN_FRAMES-1 SHALL move to IDLE.
REQ-022 Releasing the fire key during ACTIVE or COOLDOWN SHALL NOT shorten either phase; keys are ignored outside IDLE.
REQ-023 Holding the fire key SHALL auto-refire: ACTIVE re-entered one Clk after IDLE is reached, provided ammo>0.
REQ-024 attack_on SHALL be registered and equal to (state==ACTIVE); attack_dir SHALL hold constant through ACTIVE and COOLDOWN.
REQ-025 A frame tick coinciding with IDLE->ACTIVE entry SHALL NOT be counted; the entry Clk clears the counter.
REQ-026 IDLE, fire key with ammo==0: request SHALL be ignored; no hit_pulse; ammo stays 0.
REQ-027 The frame counter SHALL be 8 bits and SHALL never wrap; ammo SHALL never underflow below 0.

Reset
REQ-028 On Reset: state=IDLE, attack_on=0, attack_dir=0, hit_pulse=0, ammo=AMMO_MAX, counter=0, synchroniser and tick flops cleared.
REQ-029 Reset asserted mid-ACTIVE/COOLDOWN/RELOAD SHALL abort the operation on that Clk; no pending hit_pulse survives reset.

Configuration
REQ-030 Macro ATTACK_AMMO_RELOAD_EN defined: ammo counting and RELOAD state included; IDLE with keycode==RELOAD_KEY and ammo<AMMO_MAX SHALL enter RELOAD; the tick with counter==RELOAD_FRAMES-1 SHALL set ammo=AMMO_MAX and return to IDLE; RELOAD_KEY with full ammo ignored.
REQ-031 Macro not defined: ammo output SHALL be constant AMMO_MAX, fire never blocked, RELOAD unreachable, RELOAD_KEY ignored.

Verification
REQ-032 Reset, keycode=44 for one Clk, ticks every 100 Clk -> hit_pulse one Clk, attack_on high for exactly 4 ticks, state COOLDOWN 8 ticks, then IDLE; ammo 10->9.
REQ-033 Hold keycode=44 for 40 ticks -> attacks start every 12 ticks plus one Clk; 4 hit_pulses in 40 ticks; ammo 10->6.
REQ-034 Player_Direction=2 at fire, changed to 3 during ACTIVE -> attack_dir stays 2 until next attack.
REQ-035 (macro on) Fire 10 times, then keycode=44 -> no hit_pulse, ammo 0; keycode=21 -> RELOAD for 60 ticks, ammo=10, IDLE.
REQ-036 Frame tick on same Clk as fire entry -> ACTIVE still lasts 4 full subsequent ticks.
REQ-037 Reset asserted at tick 2 of ACTIVE -> next Clk state IDLE, attack_on 0, ammo 10.

Source files
------------

// File: rtl/attack_ctrl.sv
// Attack sequencer: fire key -> ACTIVE -> COOLDOWN -> IDLE, timed in vsync frame ticks.
// Optional magazine/reload support is compiled in with `define ATTACK_AMMO_RELOAD_EN.
module attack_ctrl #(
  parameter logic [7:0]  FIRE_KEY        = 8'd44,
  parameter logic [7:0]  RELOAD_KEY      = 8'd21,
  parameter int unsigned ACTIVE_FRAMES   = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned AMMO_MAX        = 10,
  parameter int unsigned RELOAD_FRAMES   = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [1:0] Player_Direction,
  output logic       attack_on,
  output logic [1:0] attack_dir,
  output logic       hit_pulse,
  output logic [3:0] ammo,
  output logic [1:0] state
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned AMMO_W = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;
  localparam logic [1:0] ST_RELOAD   = 2'd3;

  localparam logic [CNT_W-1:0]  ACTIVE_LAST   = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]  COOLDOWN_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [AMMO_W-1:0] AMMO_FULL     = AMMO_W'(AMMO_MAX);

  logic [2:0]        sync_q;
  logic              tick_q;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AMMO_W-1:0] ammo_q, ammo_d;
  logic [1:0]        dir_q, dir_d;
  logic              attack_on_q;
  logic              hit_q;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              fire_ok_c;

  // Two-flop synchroniser plus edge-history flop; tick is a registered rising-edge strobe
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= 3'b000;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  // Saturating increment keeps the frame counter from ever wrapping
  assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef ATTACK_AMMO_RELOAD_EN
  localparam logic [CNT_W-1:0] RELOAD_LAST = CNT_W'(RELOAD_FRAMES - 1);
  assign fire_ok_c = (ammo_q != '0);
`else
  logic unused_reload_c;
  assign unused_reload_c = ^{RELOAD_KEY, CNT_W'(RELOAD_FRAMES)};
  assign fire_ok_c = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ammo_d  = ammo_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (keycode == FIRE_KEY && fire_ok_c) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          dir_d   = Player_Direction;
`ifdef ATTACK_AMMO_RELOAD_EN
          ammo_d  = ammo_q - AMMO_W'(1);
`endif
        end
`ifdef ATTACK_AMMO_RELOAD_EN
        else if (keycode == RELOAD_KEY && ammo_q < AMMO_FULL) begin
          state_d = ST_RELOAD;
          cnt_d   = '0;
        end
`endif
      end
      ST_ACTIVE: begin
        if (tick_q) begin
          if (cnt_q == ACTIVE_LAST) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_COOLDOWN: begin
        if (tick_q) begin
          if (cnt_q == COOLDOWN_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_RELOAD: begin
`ifdef ATTACK_AMMO_RELOAD_EN
        if (tick_q) begin
          if (cnt_q == RELOAD_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ammo_d  = AMMO_FULL;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
`else
        state_d = ST_IDLE;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; hit strobes only on the IDLE->ACTIVE edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ammo_q      <= AMMO_FULL;
      dir_q       <= 2'd0;
      attack_on_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ammo_q      <= ammo_d;
      dir_q       <= dir_d;
      attack_on_q <= (state_d == ST_ACTIVE);
      hit_q       <= (state_q == ST_IDLE) && (state_d == ST_ACTIVE);
    end
  end

  assign state      = state_q;
  assign attack_on  = attack_on_q;
  assign attack_dir = dir_q;
  assign hit_pulse  = hit_q;
  assign ammo       = ammo_q;

endmodule

// File: tb/tb_attack_ctrl.sv
// Scoreboard bench for attack_ctrl: stimulus pushes expected hits, a monitor pops on hit_pulse.
// Reload scenarios run when ATTACK_AMMO_RELOAD_EN is defined.
module tb_attack_ctrl;

  typedef struct packed {
    logic [1:0] dir;
    logic [3:0] ammo;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic [1:0] Player_Direction = 2'd0;
  logic       attack_on;
  logic [1:0] attack_dir;
  logic       hit_pulse;
  logic [3:0] ammo;
  logic [1:0] state;

  int   n_checks = 0;
  int   n_pass = 0;
  int   hits_seen = 0;
  int   model_ammo = 10;
  exp_t exp_q[$];

  attack_ctrl dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_clk        (frame_clk),
    .keycode          (keycode),
    .Player_Direction (Player_Direction),
    .attack_on        (attack_on),
    .attack_dir       (attack_dir),
    .hit_pulse        (hit_pulse),
    .ammo             (ammo),
    .state            (state)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected record for the next attack start, ammo already decremented when counting is on
  task automatic push_hit(input logic [1:0] dir);
    exp_t e;
`ifdef ATTACK_AMMO_RELOAD_EN
    model_ammo = model_ammo - 1;
`endif
    e.dir  = dir;
    e.ammo = 4'(model_ammo);
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (!Reset && hit_pulse) begin
      hits_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_hit", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit_dir", int'(attack_dir), int'(e.dir));
        chk("hit_ammo", int'(ammo), int'(e.ammo));
        chk("hit_state", int'(state), 1);
        chk("hit_attack_on", int'(attack_on), 1);
      end
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; keycode = 8'd0; frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_ammo = 10;
    hits_seen = 0;
  endtask

  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (50) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (49) @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk) keycode = k;
    @(negedge Clk) keycode = 8'd0;
  endtask

  task automatic ticks_expect(input int n, input int first_idx, input int last_active);
    for (int i = first_idx; i < first_idx + n; i++) begin
      tick();
      chk($sformatf("state_tick%0d", i), int'(state), (i <= last_active) ? 1 : ((i < 12) ? 2 : 0));
      chk($sformatf("attack_on_tick%0d", i), int'(attack_on), (i <= last_active) ? 1 : 0);
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    @(negedge Clk);
    chk("rst_state", int'(state), 0);
    chk("rst_attack_on", int'(attack_on), 0);
    chk("rst_hit", int'(hit_pulse), 0);
    chk("rst_ammo", int'(ammo), 10);
    chk("rst_dir", int'(attack_dir), 0);

    // Single shot: ACTIVE for 4 ticks, COOLDOWN for 8, then IDLE
    Player_Direction = 2'd1;
    push_hit(2'd1);
    press(8'd44);
    chk("fire_state", int'(state), 1);
    ticks_expect(12, 1, 3);
    chk("single_ammo", int'(ammo), model_ammo);
    chk("single_hits", hits_seen, 1);

    // Held fire key auto-refires every 12 ticks plus one clock
    do_reset();
    Player_Direction = 2'd0;
    for (int i = 0; i < 4; i++) push_hit(2'd0);
    @(negedge Clk) keycode = 8'd44;
    repeat (40) tick();
    keycode = 8'd0;
    chk("hold_hits", hits_seen, 4);
    chk("hold_ammo", int'(ammo), model_ammo);
    chk("hold_state_cd", int'(state), 2);
    repeat (8) tick();
    chk("hold_state_idle", int'(state), 0);
    chk("hold_no_extra", hits_seen, 4);

    // Direction latched at fire, held through ACTIVE and COOLDOWN
    do_reset();
    Player_Direction = 2'd2;
    push_hit(2'd2);
    press(8'd44);
    tick();
    Player_Direction = 2'd3;
    tick();
    chk("dir_active", int'(attack_dir), 2);
    repeat (4) tick();
    chk("dir_cooldown_state", int'(state), 2);
    chk("dir_cooldown", int'(attack_dir), 2);
    repeat (6) tick();
    chk("dir_idle_state", int'(state), 0);
    push_hit(2'd3);
    press(8'd44);
    chk("dir_next", int'(attack_dir), 3);
    repeat (12) tick();

    // Frame tick landing on the entry clock is not counted
    do_reset();
    Player_Direction = 2'd1;
    push_hit(2'd1);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    keycode = 8'd44;
    @(negedge Clk) keycode = 8'd0;
    chk("coin_state", int'(state), 1);
    repeat (46) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (49) @(negedge Clk);
    ticks_expect(12, 1, 3);

    // Reset mid-ACTIVE aborts the attack
    do_reset();
    push_hit(2'd1);
    press(8'd44);
    repeat (2) tick();
    chk("mid_state_pre", int'(state), 1);
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    model_ammo = 10;
    chk("abort_state", int'(state), 0);
    chk("abort_attack_on", int'(attack_on), 0);
    chk("abort_ammo", int'(ammo), 10);
    chk("abort_hit", int'(hit_pulse), 0);
    chk("abort_dir", int'(attack_dir), 0);

`ifdef ATTACK_AMMO_RELOAD_EN
    // Drain the magazine, blocked fire, then a full reload
    do_reset();
    press(8'd21);
    chk("reload_full_ignored", int'(state), 0);
    for (int i = 0; i < 10; i++) begin
      push_hit(2'd1);
      press(8'd44);
      repeat (12) tick();
    end
    chk("empty_ammo", int'(ammo), 0);
    press(8'd44);
    tick();
    chk("empty_state", int'(state), 0);
    chk("empty_ammo_hold", int'(ammo), 0);
    chk("empty_hits", hits_seen, 10);
    press(8'd21);
    chk("reload_enter", int'(state), 3);
    repeat (59) tick();
    chk("reload_hold", int'(state), 3);
    chk("reload_ammo_pre", int'(ammo), 0);
    tick();
    chk("reload_done_state", int'(state), 0);
    chk("reload_done_ammo", int'(ammo), 10);
`else
    // Without ammo counting, reload key is ignored and ammo is pinned full
    do_reset();
    press(8'd21);
    tick();
    chk("reload_ignored_state", int'(state), 0);
    chk("reload_ignored_ammo", int'(ammo), 10);
`endif

    repeat (4) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
